// File: rtl/gpu_axi_pkg.sv
// gpu_axi_pkg: AXI3 constants and the states of the framebuffer scanout FSM.
package gpu_axi_pkg;
    localparam logic [2:0] AXI_SIZE_4B       = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
    localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;
    localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
    typedef enum logic [1:0] {IDLE, REQ, DATA, DRAIN} scan_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a show-ahead read port and a free-word count
// that lets the reader reserve room for a whole burst before issuing it.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      free
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d, count;
    always_comb begin
        count = wr_q - rd_q;
        full  = count == (AW+1)'(DEPTH);
        empty = count == '0;
        free  = (AW+1)'(DEPTH) - count;
        wr_d  = wr_q + (AW+1)'(push && !full);
        rd_d  = rd_q + (AW+1)'(pop && !empty);
        rdata = mem[rd_q[AW-1:0]];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
        if (push && !full) mem[wr_q[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/fb_scanout_axi3_reader.sv
// fb_scanout_axi3_reader: fetches an 8-bit framebuffer over AXI3 INCR bursts and
// replays it as a raster-ordered pixel stream with x/y coordinates.
module fb_scanout_axi3_reader
    import gpu_axi_pkg::*;
#(
    parameter int FIFO_DEPTH = 64,
    parameter int BURST_LEN  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] framebuffer_baseaddr,
    input  logic [10:0] width,
    input  logic [10:0] height,
    output logic        busy,
    output logic        frame_done,
    output logic        error,
    output logic [7:0]  pixel_data,
    output logic [10:0] pixel_x,
    output logic [10:0] pixel_y,
    output logic        pixel_valid,
    input  logic        pixel_ready,
    output logic [31:0] M00_AXI_araddr,
    output logic [3:0]  M00_AXI_arlen,
    output logic [2:0]  M00_AXI_arsize,
    output logic [1:0]  M00_AXI_arburst,
    output logic [1:0]  M00_AXI_arlock,
    output logic [3:0]  M00_AXI_arcache,
    output logic [2:0]  M00_AXI_arprot,
    output logic [3:0]  M00_AXI_arqos,
    output logic [3:0]  M00_AXI_aruser,
    output logic        M00_AXI_arvalid,
    input  logic        M00_AXI_arready,
    input  logic [31:0] M00_AXI_rdata,
    input  logic [1:0]  M00_AXI_rresp,
    input  logic        M00_AXI_rlast,
    input  logic        M00_AXI_rvalid,
    output logic        M00_AXI_rready
);
    localparam int FAW = $clog2(FIFO_DEPTH);
    scan_state_e state_q, state_d;
    logic [18:0] beats_left_q, beats_left_d;
    logic [31:0] next_addr_q, next_addr_d, araddr_q, araddr_d, word_q, word_d, fifo_rdata;
    logic [10:0] width_q, width_d, height_q, height_d, x_q, x_d, y_q, y_d;
    logic [3:0]  arlen_q, arlen_d, beat_q, beat_d;
    logic [1:0]  byte_q, byte_d;
    logic        arvalid_q, arvalid_d, error_q, error_d, hold_q, hold_d;
    logic        r_hs, pix_hs, x_wrap, pix_last, fifo_pop, fifo_full, fifo_empty;
    logic [FAW:0] fifo_free;

    assign M00_AXI_araddr  = araddr_q;
    assign M00_AXI_arlen   = arlen_q;
    assign M00_AXI_arsize  = AXI_SIZE_4B;
    assign M00_AXI_arburst = AXI_BURST_INCR;
    assign M00_AXI_arlock  = 2'b00;
    assign M00_AXI_arcache = AXI_CACHE_DEFAULT;
    assign M00_AXI_arprot  = 3'b000;
    assign M00_AXI_arqos   = 4'b0000;
    assign M00_AXI_aruser  = 4'b0000;
    assign M00_AXI_arvalid = arvalid_q;
    assign M00_AXI_rready  = state_q == DATA && !fifo_full;
    assign busy            = state_q != IDLE;
    assign error           = error_q;
    assign pixel_valid     = hold_q;
    assign pixel_data      = word_q[{byte_q, 3'b000} +: 8];
    assign pixel_x         = x_q;
    assign pixel_y         = y_q;

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .push(r_hs), .wdata(M00_AXI_rdata), .pop(fifo_pop),
        .rdata(fifo_rdata), .full(fifo_full), .empty(fifo_empty), .free(fifo_free)
    );

    always_comb begin
        r_hs         = M00_AXI_rvalid && M00_AXI_rready;
        pix_hs       = hold_q && pixel_ready;
        x_wrap       = x_q == width_q - 11'd1;
        pix_last     = x_wrap && y_q == height_q - 11'd1;
        frame_done   = pix_hs && pix_last;
        fifo_pop     = !fifo_empty && (!hold_q || (pix_hs && byte_q == 2'd3));
        state_d      = state_q;
        beats_left_d = beats_left_q;
        next_addr_d  = next_addr_q;
        width_d      = width_q;
        height_d     = height_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        arvalid_d    = arvalid_q;
        beat_d       = beat_q;
        error_d      = error_q;
        case (state_q)
            IDLE: if (start) begin
                state_d      = REQ;
                beats_left_d = {10'd0, width[10:2]} * {8'd0, height};
                next_addr_d  = framebuffer_baseaddr;
                width_d      = width;
                height_d     = height;
                error_d      = 1'b0;
            end
            REQ: if (arvalid_q && M00_AXI_arready) begin
                state_d      = DATA;
                arvalid_d    = 1'b0;
                beat_d       = 4'd0;
                next_addr_d  = next_addr_q + {26'd0, arlen_q, 2'b00} + 32'd4;
                beats_left_d = beats_left_q - {15'd0, arlen_q} - 19'd1;
            end else if (!arvalid_q && fifo_free >= (FAW+1)'(BURST_LEN)) begin
                // Issue only once a full burst fits, so the FIFO can never overflow.
                arvalid_d = 1'b1;
                araddr_d  = next_addr_q;
                arlen_d   = beats_left_q < 19'(BURST_LEN) ? beats_left_q[3:0] - 4'd1 : 4'(BURST_LEN - 1);
            end
            DATA: if (r_hs) begin
                beat_d  = beat_q + 4'd1;
                error_d = error_q || M00_AXI_rresp != AXI_RESP_OKAY || M00_AXI_rlast != (beat_q == arlen_q);
                state_d = beat_q != arlen_q ? DATA : beats_left_q != '0 ? REQ : DRAIN;
            end
            DRAIN: if (frame_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        word_d = fifo_pop ? fifo_rdata : word_q;
        hold_d = fifo_pop || (hold_q && !(pix_hs && byte_q == 2'd3));
        byte_d = fifo_pop ? 2'd0 : pix_hs ? byte_q + 2'd1 : byte_q;
        x_d    = !pix_hs ? x_q : x_wrap ? 11'd0 : x_q + 11'd1;
        y_d    = !pix_hs || !x_wrap ? y_q : pix_last ? 11'd0 : y_q + 11'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            beats_left_q <= '0;
            next_addr_q  <= '0;
            width_q      <= '0;
            height_q     <= '0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arvalid_q    <= 1'b0;
            beat_q       <= '0;
            error_q      <= 1'b0;
            word_q       <= '0;
            hold_q       <= 1'b0;
            byte_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
        end else begin
            state_q      <= state_d;
            beats_left_q <= beats_left_d;
            next_addr_q  <= next_addr_d;
            width_q      <= width_d;
            height_q     <= height_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arvalid_q    <= arvalid_d;
            beat_q       <= beat_d;
            error_q      <= error_d;
            word_q       <= word_d;
            hold_q       <= hold_d;
            byte_q       <= byte_d;
            x_q          <= x_d;
            y_q          <= y_d;
        end
    end
endmodule

// File: tb/tb_fb_scanout_axi3_reader.sv
// tb_fb_scanout_axi3_reader: AXI3 slave model plus pixel scoreboard for the scanout reader.
module tb_fb_scanout_axi3_reader;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, pixel_ready = 1'b0;
    logic [31:0] base = '0;
    logic [10:0] width = '0, height = '0;
    logic        busy, frame_done, error, pixel_valid;
    logic [7:0]  pixel_data;
    logic [10:0] pixel_x, pixel_y;
    logic [31:0] araddr;
    logic [3:0]  arlen, arcache, arqos, aruser;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock;
    logic        arvalid, rready;
    logic        arready = 1'b0, rvalid = 1'b0, rlast = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;

    always #5 clk = ~clk;

    fb_scanout_axi3_reader dut (
        .clk(clk), .reset(reset), .start(start), .framebuffer_baseaddr(base),
        .width(width), .height(height), .busy(busy), .frame_done(frame_done), .error(error),
        .pixel_data(pixel_data), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .M00_AXI_araddr(araddr), .M00_AXI_arlen(arlen), .M00_AXI_arsize(arsize),
        .M00_AXI_arburst(arburst), .M00_AXI_arlock(arlock), .M00_AXI_arcache(arcache),
        .M00_AXI_arprot(arprot), .M00_AXI_arqos(arqos), .M00_AXI_aruser(aruser),
        .M00_AXI_arvalid(arvalid), .M00_AXI_arready(arready), .M00_AXI_rdata(rdata),
        .M00_AXI_rresp(rresp), .M00_AXI_rlast(rlast), .M00_AXI_rvalid(rvalid),
        .M00_AXI_rready(rready)
    );

    typedef struct packed {logic [7:0] d; logic [10:0] x; logic [10:0] y; logic last;} pix_t;
    pix_t sb[$];
    int n_vec = 0, n_bad = 0;
    int ar_cnt = 0, pix_cnt = 0, done_cnt = 0, beat_glb = 0, bad_resp_beat = -1, ready_mode = 0;
    logic [31:0] exp_addr = '0, fr_base = '0, prev_araddr = '0, b_addr = '0;
    logic [18:0] exp_left = '0;
    logic [10:0] sx = '0, sy = '0, fw = 11'd1, fh = 11'd1, done_x = '0, done_y = '0;
    logic [3:0]  b_len = '0, b_beat = '0, prev_arlen = '0;
    bit gaps = 0, bad_rlast = 0, slave_flush = 0, b_act = 0, prev_ar_wait = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Byte at frame offset o holds o[7:0]^o[15:8], so row 0 of small frames reads 0,1,2,...
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w, o;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            o = a - fr_base + 32'(i);
            w[8*i +: 8] = o[7:0] ^ o[15:8];
        end
        return w;
    endfunction

    initial begin
        forever begin
            logic ar_hs, r_hs, p_hs, end_burst;
            logic [3:0] exp_len;
            pix_t e;
            @(negedge clk);
            if (slave_flush) begin
                b_act = 0; rvalid = 1'b0; rlast = 1'b0; sb.delete();
                sx = '0; sy = '0; prev_ar_wait = 0; slave_flush = 0;
            end
            ar_hs = !reset && arvalid && arready;
            r_hs  = !reset && rvalid && rready;
            p_hs  = !reset && pixel_valid && pixel_ready;
            if (!reset && prev_ar_wait) begin
                chk("arvalid_hold", 32'(arvalid), 1);
                chk("araddr_hold", araddr, prev_araddr);
                chk("arlen_hold", 32'(arlen), 32'(prev_arlen));
            end
            prev_ar_wait = !reset && arvalid && !arready;
            prev_araddr = araddr;
            prev_arlen = arlen;
            if (ar_hs) begin
                exp_len = exp_left < 19'd16 ? 4'(exp_left - 19'd1) : 4'd15;
                chk("ar_single_outstanding", 32'(b_act), 0);
                chk("araddr", araddr, exp_addr);
                chk("arlen", 32'(arlen), 32'(exp_len));
                exp_addr = exp_addr + {26'd0, exp_len, 2'b00} + 32'd4;
                exp_left = exp_left - {15'd0, exp_len} - 19'd1;
                ar_cnt++;
            end
            if (r_hs) begin
                for (int i = 0; i < 4; i++) begin
                    sb.push_back('{d: rdata[8*i +: 8], x: sx, y: sy, last: (sx == fw - 11'd1 && sy == fh - 11'd1)});
                    if (sx == fw - 11'd1) begin
                        sx = '0;
                        sy = sy == fh - 11'd1 ? 11'd0 : sy + 11'd1;
                    end else sx = sx + 11'd1;
                end
                beat_glb++;
            end
            if (p_hs) begin
                chk("sb_avail", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("pixel_data", 32'(pixel_data), 32'(e.d));
                    chk("pixel_x", 32'(pixel_x), 32'(e.x));
                    chk("pixel_y", 32'(pixel_y), 32'(e.y));
                    chk("frame_done", 32'(frame_done), 32'(e.last));
                end
                pix_cnt++;
            end
            if (!reset && frame_done) begin
                done_cnt++;
                done_x = pixel_x;
                done_y = pixel_y;
            end
            @(posedge clk);
            #1;
            if (ar_hs) begin
                b_act = 1; b_addr = prev_araddr; b_len = prev_arlen; b_beat = '0;
            end
            if (r_hs) begin
                end_burst = b_beat == b_len;
                b_beat = b_beat + 4'd1;
                if (end_burst) b_act = 0;
            end
            rvalid = b_act && ((rvalid && !r_hs) || !gaps || $urandom_range(0, 3) != 0);
            rdata = mem_word(b_addr + {26'd0, b_beat, 2'b00});
            rlast = bad_rlast ? (b_len != '0 && b_beat == b_len - 4'd1) : (b_beat == b_len);
            rresp = beat_glb == bad_resp_beat ? 2'b10 : 2'b00;
            arready = !gaps || $urandom_range(0, 1) != 0;
            pixel_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame_start(input logic [31:0] b, input logic [10:0] w, input logic [10:0] h);
        int nb;
        nb = int'(w) * int'(h) / 4;
        fr_base = b; fw = w; fh = h; exp_addr = b; exp_left = nb[18:0];
        sx = '0; sy = '0; ar_cnt = 0; pix_cnt = 0; beat_glb = 0;
        base = b; width = w; height = h;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0, n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt - d0), 1);
        chk({tag, "_busy_at_done"}, 32'(busy), 1);
        @(negedge clk);
        #1;
        chk({tag, "_busy_after"}, 32'(busy), 0);
        chk({tag, "_sb_empty"}, 32'(sb.size()), 0);
        chk({tag, "_xy_home"}, {pixel_x, pixel_y}, 0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_frame_done"}, 32'(frame_done), 0);
        chk({tag, "_error"}, 32'(error), 0);
        chk({tag, "_arvalid"}, 32'(arvalid), 0);
        chk({tag, "_rready"}, 32'(rready), 0);
        chk({tag, "_pixel_valid"}, 32'(pixel_valid), 0);
        chk({tag, "_araddr"}, araddr, 0);
        chk({tag, "_arlen"}, 32'(arlen), 0);
        chk({tag, "_pixel"}, {pixel_data, pixel_x, pixel_y}, 0);
    endtask

    initial begin
        int n;
        tick(3);
        @(negedge clk);
        #1;
        check_reset_state("rst");
        chk("arsize", 32'(arsize), 2);
        chk("arburst", 32'(arburst), 1);
        chk("arcache", 32'(arcache), 3);
        chk("ar_zero_consts", {arlock, arprot, arqos, aruser}, 0);
        tick(1);
        reset = 1'b0;
        tick(2);

        frame_start(32'h1000, 11'd8, 11'd2);
        wait_done("f8x2", 300);
        chk("f8x2_ar_cnt", 32'(ar_cnt), 1);
        chk("f8x2_pix_cnt", 32'(pix_cnt), 16);
        chk("f8x2_error", 32'(error), 0);
        tick(2);

        frame_start(32'h0, 11'd256, 11'd32);
        wait_done("big", 20000);
        chk("big_ar_cnt", 32'(ar_cnt), 128);
        chk("big_pix_cnt", 32'(pix_cnt), 8192);
        chk("big_last_xy", {done_x, done_y}, {11'd255, 11'd31});
        tick(2);

        bad_rlast = 1;
        frame_start(32'h2000, 11'd12, 11'd1);
        wait_done("rlast", 300);
        chk("rlast_ar_cnt", 32'(ar_cnt), 1);
        chk("rlast_error", 32'(error), 1);
        chk("rlast_pix_cnt", 32'(pix_cnt), 12);
        bad_rlast = 0;
        tick(2);

        ready_mode = 1;
        frame_start(32'h0, 11'd256, 11'd32);
        tick(500);
        @(negedge clk);
        #1;
        chk("stall_ar_cnt", 32'(ar_cnt), 4);
        chk("stall_arvalid", 32'(arvalid), 0);
        chk("stall_pix_cnt", 32'(pix_cnt), 0);
        tick(1);
        ready_mode = 0;
        wait_done("stall", 20000);
        chk("stall_pix_total", 32'(pix_cnt), 8192);
        chk("stall_ar_total", 32'(ar_cnt), 128);
        tick(2);

        gaps = 1; bad_resp_beat = 5; ready_mode = 2;
        frame_start(32'h4000, 11'd64, 11'd4);
        tick(20);
        chk("resp_busy_mid", 32'(busy), 1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done("resp", 5000);
        chk("resp_ar_cnt", 32'(ar_cnt), 4);
        chk("resp_pix_cnt", 32'(pix_cnt), 256);
        chk("resp_error", 32'(error), 1);
        tick(5);
        chk("resp_error_sticky", 32'(error), 1);
        gaps = 0; bad_resp_beat = -1; ready_mode = 0;
        tick(2);

        frame_start(32'h5000, 11'd8, 11'd2);
        @(negedge clk);
        #1;
        chk("error_cleared", 32'(error), 0);
        wait_done("clr", 300);
        chk("clr_pix_cnt", 32'(pix_cnt), 16);
        tick(2);

        frame_start(32'h0, 11'd256, 11'd32);
        n = 0;
        while (!(ar_cnt >= 2 && b_act) && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("midburst_reached", 32'(ar_cnt >= 2 && b_act), 1);
        tick(1);
        reset = 1'b1;
        tick(1);
        @(negedge clk);
        #1;
        check_reset_state("midrst");
        tick(1);
        @(negedge clk);
        #1;
        chk("midrst_rready_held", 32'(rready), 0);
        tick(1);
        reset = 1'b0;
        slave_flush = 1;
        tick(2);
        frame_start(32'h3000, 11'd8, 11'd2);
        wait_done("post_rst", 300);
        chk("post_rst_ar_cnt", 32'(ar_cnt), 1);
        chk("post_rst_pix_cnt", 32'(pix_cnt), 16);
        chk("post_rst_error", 32'(error), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
        $fatal(1, "watchdog");
    end
endmodule
